// File: rtl/countdown_ctrl.sv
// Seconds countdown controller: preset entry, start/pause/resume/stop, 1 s tick, expiry/alarm.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry instead of alarming.
module countdown_ctrl #(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned MAX_COUNT      = 99,
  parameter int unsigned DEFAULT_PRESET = 59,
  parameter int unsigned ALARM_SECS     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [6:0] count,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       alarm
);

  localparam int unsigned CW = 7;
  localparam int unsigned DW = 32;

  localparam logic [CW-1:0] MAX_C      = CW'(MAX_COUNT);
  localparam logic [CW-1:0] DEF_C      = CW'(DEFAULT_PRESET);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_FREQ_HZ - 1);
  localparam logic [DW-1:0] ALARM_LAST = DW'(ALARM_SECS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] preset_q, preset_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] asec_q, asec_d;
  logic          expired_q, expired_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  // Next-state, counters and flag logic; button priority is stop > start > up > down
  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    count_d   = count_q;
    div_d     = div_q;
    asec_d    = asec_q;
    expired_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!btn_stop) begin
          if (btn_start) begin
            if (preset_q != '0) begin
              state_d = S_RUN;
              div_d   = '0;
            end
          end else if (btn_up) begin
            preset_d = (preset_q == MAX_C) ? '0 : preset_q + CW'(1);
          end else if (btn_down) begin
            preset_d = (preset_q == '0) ? MAX_C : preset_q - CW'(1);
          end
        end
        count_d = preset_d;
      end

      S_RUN: begin
        if (btn_stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          div_d = '0;
          if (count_q > CW'(1)) begin
            count_d = count_q - CW'(1);
          end else begin
            expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_d   = preset_q;
`else
            count_d   = '0;
            state_d   = S_EXPIRED;
            asec_d    = '0;
`endif
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_PAUSE: begin
        if (btn_stop) begin
          state_d = S_IDLE;
          count_d = preset_q;
        end else if (btn_start) begin
          state_d = S_RUN;
        end
      end

      S_EXPIRED: begin
        if (btn_stop || btn_start) begin
          state_d = S_IDLE;
          count_d = preset_q;
        end else if (tick) begin
          div_d = '0;
          if (asec_q == ALARM_LAST) begin
            state_d = S_IDLE;
            count_d = preset_q;
          end else begin
            asec_d = asec_q + DW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      preset_q  <= DEF_C;
      count_q   <= DEF_C;
      div_q     <= '0;
      asec_q    <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      div_q     <= div_d;
      asec_q    <= asec_d;
      expired_q <= expired_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  // Digit split feeds the 7-segment decoder directly
  assign count   = count_q;
  assign tens    = 4'(count_q / CW'(10));
  assign ones    = 4'(count_q % CW'(10));
  assign running = running_q;
  assign expired = expired_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Randomized + directed bench for countdown_ctrl against a cycle-count based reference model.
module tb_countdown_ctrl;

  localparam int F     = 10;
  localparam int MAXC  = 99;
  localparam int DEF   = 59;
  localparam int ALARM = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [6:0] count;
  logic [3:0] tens, ones;
  logic       running, expired, alarm;

  countdown_ctrl #(
    .CLK_FREQ_HZ(F), .MAX_COUNT(MAXC), .DEFAULT_PRESET(DEF), .ALARM_SECS(ALARM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_up(btn_up), .btn_down(btn_down),
    .count(count), .tens(tens), .ones(ones),
    .running(running), .expired(expired), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Reference model: modes as plain ints, time kept as total cycles spent running / alarming
  int cyc = 0;
  int m_mode = 0;          // 0 idle, 1 run, 2 pause, 3 alarm
  int m_preset = DEF;
  int m_run = 0;           // clock edges spent in RUN since start
  int m_exp = 0;           // clock edges spent alarming
  bit m_pulse = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_pulse = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_preset = DEF; m_run = 0; m_exp = 0;
    end else begin
      case (m_mode)
        0: if (!btn_stop) begin
             if (btn_start) begin
               if (m_preset != 0) begin m_mode = 1; m_run = 0; end
             end else if (btn_up) m_preset = (m_preset == MAXC) ? 0 : m_preset + 1;
             else if (btn_down) m_preset = (m_preset == 0) ? MAXC : m_preset - 1;
           end
        1: if (btn_stop) m_mode = 2;
           else begin
             m_run++;
             if (m_run % F == 0 && (m_run / F) % m_preset == 0) begin
               m_pulse = 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
               m_mode = 3; m_exp = 0;
`endif
             end
           end
        2: if (btn_stop) m_mode = 0; else if (btn_start) m_mode = 1;
        3: if (btn_stop || btn_start) m_mode = 0;
           else begin
             m_exp++;
             if (m_exp == ALARM * F) m_mode = 0;
           end
        default: m_mode = 0;
      endcase
    end
  end

  function automatic int m_count();
    case (m_mode)
      1, 2:    return (m_preset == 0) ? 0 : m_preset - (m_run / F) % m_preset;
      3:       return 0;
      default: return m_preset;
    endcase
  endfunction

  function automatic int exp_val(int sig);
    case (sig)
      0: return m_count();
      1: return m_count() / 10;
      2: return m_count() % 10;
      3: return int'(m_mode == 1);
      4: return int'(m_pulse);
      default: return int'(m_mode == 3);
    endcase
  endfunction

  function automatic int dut_val(int sig);
    case (sig)
      0: return int'(count);
      1: return int'(tens);
      2: return int'(ones);
      3: return int'(running);
      4: return int'(expired);
      default: return int'(alarm);
    endcase
  endfunction

  // Hand-computed expectations pinned to specific cycles
  typedef struct { int c; int sig; int val; } pin_t;
  pin_t pins[$];
  string sname[6] = '{"count", "tens", "ones", "running", "expired", "alarm"};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  // Single compare process: model every cycle, pinned literals on their cycle
  always @(negedge clk) begin
    pin_t keep[$];
    if (chk_en)
      for (int s = 0; s < 6; s++) chk(sname[s], dut_val(s), exp_val(s));
    keep = {};
    foreach (pins[i]) begin
      if (pins[i].c == cyc) chk({"pin_", sname[pins[i].sig]}, dut_val(pins[i].sig), pins[i].val);
      else keep.push_back(pins[i]);
    end
    pins = keep;
  end

  task automatic pin(input int c, input int sig, input int val);
    pin_t p;
    p.c = c; p.sig = sig; p.val = val;
    pins.push_back(p);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic press(input bit st, input bit sp, input bit u, input bit d);
    btn_start = st; btn_stop = sp; btn_up = u; btn_down = d;
    @(posedge clk); #1;
    btn_start = 1'b0; btn_stop = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  int t, p, r, target;

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pin(cyc, 0, 59); pin(cyc, 1, 5); pin(cyc, 2, 9);
    pin(cyc, 3, 0);  pin(cyc, 4, 0); pin(cyc, 5, 0);

    // Preset entry and wrap
    repeat (40) press(0, 0, 1, 0);
    pin(cyc, 0, 99);
    press(0, 0, 1, 0); pin(cyc, 0, 0);
    press(0, 0, 0, 1); pin(cyc, 0, 99);
    repeat (11) press(0, 0, 1, 0); pin(cyc, 0, 10);
    press(0, 0, 1, 1); pin(cyc, 0, 11);
    repeat (8) press(0, 0, 0, 1); pin(cyc, 0, 3); pin(cyc, 1, 0); pin(cyc, 2, 3);

    // Full countdown from preset 3, with an ignored up press while running
    t = cyc;
    press(1, 0, 0, 0);
    pin(t + 1, 3, 1); pin(t + 10, 0, 3); pin(t + 11, 0, 2); pin(t + 21, 0, 1);
    pin(t + 30, 4, 0);
    step_to(t + 5); press(0, 0, 1, 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    pin(t + 31, 0, 0); pin(t + 31, 4, 1); pin(t + 31, 5, 1); pin(t + 31, 3, 0);
    pin(t + 32, 4, 0); pin(t + 80, 5, 1); pin(t + 81, 5, 0); pin(t + 81, 0, 3);
    step_to(t + 82);
`else
    pin(t + 31, 0, 3); pin(t + 31, 4, 1); pin(t + 31, 3, 1); pin(t + 31, 5, 0);
    pin(t + 32, 4, 0); pin(t + 61, 4, 1); pin(t + 61, 0, 3);
    step_to(t + 62);
    press(0, 1, 0, 0); press(0, 1, 0, 0);
    pin(cyc, 0, 3);
`endif

    // Pause with divider at 4, hold 50 cycles, resume
    t = cyc;
    press(1, 0, 0, 0);
    step_to(t + 5); press(0, 1, 0, 0);
    pin(t + 6, 3, 0); pin(t + 6, 0, 3); pin(t + 55, 0, 3);
    step_to(t + 56); p = cyc;
    press(1, 0, 0, 0);
    pin(p + 1, 3, 1); pin(p + 6, 0, 3); pin(p + 7, 0, 2);
    step_to(p + 10); press(1, 1, 0, 0);
    pin(cyc, 3, 0);
    press(0, 1, 0, 0);
    pin(cyc, 0, 3); pin(cyc, 3, 0); pin(cyc, 5, 0);

    // Start ignored with preset 0
    repeat (3) press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    pin(cyc, 3, 0); pin(cyc, 0, 0);
    press(0, 0, 1, 0);

    // Preset 1: acknowledge during alarm (or repeated reload)
    t = cyc;
    press(1, 0, 0, 0);
    pin(t + 11, 4, 1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    pin(t + 11, 5, 1);
    step_to(t + 13); press(0, 1, 0, 0);
    pin(t + 14, 5, 0); pin(t + 14, 0, 1);
`else
    pin(t + 21, 4, 1); pin(t + 21, 3, 1); pin(t + 21, 0, 1);
    step_to(t + 23); press(0, 1, 0, 0); press(0, 1, 0, 0);
`endif

    // Reset mid-run
    press(1, 0, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pin(cyc, 0, 59); pin(cyc, 3, 0);

    // Randomized rounds from small presets so expiries occur
    for (int round = 0; round < 14; round++) begin
      press(0, 1, 0, 0); press(0, 1, 0, 0);
      target = $urandom_range(1, 6);
      for (int k = 0; k < 110 && m_preset != target; k++) press(0, 0, 0, 1);
      for (int k = 0; k < 300; k++) begin
        r = $urandom_range(0, 299);
        btn_start = (r < 10) || (r == 40);
        btn_stop  = (r >= 10 && r < 14) || (r == 40) || (r == 41);
        btn_up    = (r >= 20 && r < 27) || (r == 41);
        btn_down  = (r >= 30 && r < 37) || (r == 41);
        rst_n     = ($urandom_range(0, 999) != 0);
        @(posedge clk); #1;
      end
      btn_start = 1'b0; btn_stop = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      rst_n = 1'b1;
    end

    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
